// File: rtl/proj_pkgs.sv
// Shared types for the systolic-array instruction path.
// Opcodes, instruction bundle and arbiter defaults.
package proj_pkgs;

  localparam int LAP_ARB_NREQ  = 2;
  localparam int LAP_ARB_DEPTH = 4;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_MAC   = 4'd2,
    OP_STORE = 4'd3,
    OP_SYNC  = 4'd4
  } opcd_t;

  typedef struct packed {
    opcd_t       opcd;
    logic [11:0] addr;
    logic [7:0]  len;
  } sa_inst_t;

endpackage

// File: rtl/vinst_arb_rr_pick.sv
// Round-robin picker: first valid at or after ptr.
// Purely combinational, one-hot grant plus index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic found;
  int   j;

  // scan N slots starting at ptr, wrapping mod N
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vinst_arb.sv
// Instruction arbiter: round-robin grant into an
// issue queue that feeds the array controller.
module vinst_arb
  import proj_pkgs::*;
#(
  parameter int NREQ  = LAP_ARB_NREQ,
  parameter int DEPTH = LAP_ARB_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  sa_inst_t                req_inst [NREQ],
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output sa_inst_t                inst,
  output logic                    iavail,
  input  logic                    ird,
  input  logic                    next,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    ird_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(NREQ);

  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [NREQ-1:0] grant;
  logic          space;
  logic          push;
  logic          pop;

  sa_inst_t      mem_inst [DEPTH];
  logic [IW-1:0] mem_id   [DEPTH];

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .index (gidx)
  );

  // ready looks only at registered count, so a
  // same-cycle pop never opens a slot when full
  assign space     = count < CW'(DEPTH);
  assign req_ready = (reset && space) ? grant : '0;
  assign push      = |(req_valid & req_ready);
  assign pop       = ird && (count != '0);

  // queue pointers, occupancy and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gidx == IW'(NREQ - 1)) ?
                  '0 : gidx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; cleared so the head is a nop after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_id[i]   <= '0;
      end
    end else if (push) begin
      mem_inst[wr_ptr] <= req_inst[gidx];
      mem_id[wr_ptr]   <= gidx;
    end
  end

  // instructions popped but not yet retired by next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      unique case ({pop, next})
        2'b10: if (inflight != '1)
                 inflight <= inflight + 1'b1;
        2'b01: if (inflight != '0)
                 inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // sticky flag for a pop strobe on an empty queue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ird_err <= 1'b0;
    else if (ird && (count == '0))
      ird_err <= 1'b1;
  end

  assign iavail   = (count != '0);
  assign busy     = iavail | (inflight != '0);
  assign inst     = mem_inst[rd_ptr];
  assign grant_id = mem_id[rd_ptr];

endmodule

// File: tb/tb_vinst_arb.sv
// Directed bench for vinst_arb (NREQ=2, DEPTH=4).
// Immediate assertions with hand-computed values.
module tb_vinst_arb;
  import proj_pkgs::*;

  logic       clk = 1'b0;
  logic       reset;
  sa_inst_t   req_inst [2];
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  sa_inst_t   inst;
  logic       iavail;
  logic       ird;
  logic       next;
  logic [0:0] grant_id;
  logic       busy;
  logic       ird_err;

  int nvec = 0;
  int nerr = 0;

  sa_inst_t I0;
  sa_inst_t I1;
  logic [1:0] exp3 [3];

  always #5 clk = ~clk;

  vinst_arb #(.NREQ(2), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_inst  (req_inst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .inst      (inst),
    .iavail    (iavail),
    .ird       (ird),
    .next      (next),
    .grant_id  (grant_id),
    .busy      (busy),
    .ird_err   (ird_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    I0 = '{opcd: OP_LOAD, addr: 12'h010, len: 8'h01};
    I1 = '{opcd: OP_MAC,  addr: 12'h020, len: 8'h02};
    exp3[0] = 2'b01;
    exp3[1] = 2'b10;
    exp3[2] = 2'b01;
    req_inst[0] = I0;
    req_inst[1] = I1;
    reset = 1'b0;
    req_valid = 2'b00;
    ird = 1'b0;
    next = 1'b0;

    // reset state, valid held high to stress ready
    repeat (2) tick;
    req_valid = 2'b11;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_iavail", iavail, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", ird_err, 1'b0);
    chk("rst_gid", grant_id, 1'b0);
    chk("rst_opcd", inst.opcd, OP_NOP);
    req_valid = 2'b00;
    reset = 1'b1;
    tick;

    // only requester 1 valid with rr_ptr 0
    req_valid = 2'b10;
    #1;
    chk("solo1_ready", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    #1;
    chk("solo1_iavail", iavail, 1'b1);
    chk("solo1_gid", grant_id, 1'b1);
    chk("solo1_inst", inst, I1);
    chk("solo1_busy", busy, 1'b1);

    // pop with no next keeps busy via inflight
    ird = 1'b1;
    tick;
    ird = 1'b0;
    chk("pop_iavail", iavail, 1'b0);
    chk("pop_busy", busy, 1'b1);
    tick;
    chk("pop_busy2", busy, 1'b1);

    // rr_ptr wrapped back to 0 after grant 1
    req_valid = 2'b01;
    #1;
    chk("wrap_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;

    // ird and next together: inflight stays 1
    ird = 1'b1;
    next = 1'b1;
    tick;
    ird = 1'b0;
    next = 1'b0;
    chk("both_iavail", iavail, 1'b0);
    chk("both_busy", busy, 1'b1);
    next = 1'b1;
    tick;
    next = 1'b0;
    chk("next_busy", busy, 1'b0);

    // requester 1 fills the queue
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_ready", req_ready, 2'b10);
      tick;
    end
    #1;
    chk("full_iavail", iavail, 1'b1);
    chk("full_ready", req_ready, 2'b00);
    ird = 1'b1;
    #1;
    chk("full_ird_ready", req_ready, 2'b00);
    tick;
    ird = 1'b0;
    #1;
    chk("refill_ready", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("drain_gid", grant_id, 1'b1);
      ird = 1'b1;
      tick;
      ird = 1'b0;
    end
    chk("drain_iavail", iavail, 1'b0);

    // inflight now 5; retire 3 leaves 2
    next = 1'b1;
    repeat (3) tick;
    next = 1'b0;
    chk("inflight_busy", busy, 1'b1);

    // queue 3 entries, both valid, rr_ptr 0
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("three_ready", req_ready, exp3[i]);
      tick;
    end
    req_valid = 2'b00;
    chk("three_iavail", iavail, 1'b1);

    // asynchronous reset mid-operation
    #2;
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("arst_iavail", iavail, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", ird_err, 1'b0);
    chk("arst_ready", req_ready, 2'b00);
    chk("arst_gid", grant_id, 1'b0);
    chk("arst_opcd", inst.opcd, OP_NOP);
    tick;
    reset = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 2'b01);

    // both valid, pop every 4 cycles: heads alternate
    for (int p = 0; p < 6; p++) begin
      repeat (3) tick;
      chk("rr_head_gid", grant_id, p % 2);
      chk("rr_head_inst", inst, (p % 2) ? I1 : I0);
      ird = 1'b1;
      tick;
      ird = 1'b0;
    end
    req_valid = 2'b00;

    // pop strobe on empty queue after reset
    reset = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    chk("err_clear", ird_err, 1'b0);
    ird = 1'b1;
    tick;
    ird = 1'b0;
    chk("err_set", ird_err, 1'b1);
    chk("err_iavail", iavail, 1'b0);
    repeat (2) tick;
    chk("err_sticky", ird_err, 1'b1);
    chk("err_iavail2", iavail, 1'b0);
    chk("err_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
